// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for the game pipeline (clk_pixel domain).
// Each accepted frame runs the environment stream, then NUM_PHYS_STEPS physics
// substeps, then a one-cycle commit pulse that swaps the render-side buffers.
// A watchdog aborts any stage that waits longer than TIMEOUT_CYCLES.
// Optional frame-length statistics are enabled with the FRAME_SEQ_STATS_EN macro.
module frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NUM_PHYS_STEPS = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    output logic        env_start_out,
    input  logic        env_done_in,
    input  logic        obs_done_in,
    output logic        phys_start_out,
    input  logic        phys_done_in,
    output logic        commit_out,
    output logic        busy_out,
    output logic        overrun_out,
    output logic        timeout_out,
    output logic        error_out,
    output logic [7:0]  skipped_frames_out,
    output logic [20:0] last_frame_cycles_out
);

    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int STEP_W = $clog2(NUM_PHYS_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENV_START,
        ENV_WAIT,
        PHYS_START,
        PHYS_WAIT,
        COMMIT
    } state_t;

    state_t            state, state_next;
    logic              env_seen, env_seen_next;
    logic              obs_seen, obs_seen_next;
    logic [STEP_W-1:0] step_cnt, step_cnt_next;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_next;
    logic              overrun_next;
    logic              timeout_next;
    logic              wd_expired;

    // The last cycle of a wait state is the one where the watchdog reaches its limit.
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic, done latches, substep counter and watchdog.
    always_comb begin
        state_next    = state;
        env_seen_next = env_seen;
        obs_seen_next = obs_seen;
        step_cnt_next = step_cnt;
        wd_cnt_next   = wd_cnt;
        overrun_next  = 1'b0;
        timeout_next  = 1'b0;
        case (state)
            IDLE: begin
                if (new_frame_in) state_next = ENV_START;
            end
            ENV_START: begin
                overrun_next  = new_frame_in;
                env_seen_next = 1'b0;
                obs_seen_next = 1'b0;
                wd_cnt_next   = '0;
                state_next    = ENV_WAIT;
            end
            ENV_WAIT: begin
                overrun_next = new_frame_in;
                if (wd_expired) begin
                    // Abort wins over any done pulse arriving in the same cycle.
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wd_cnt_next   = wd_cnt + 1'b1;
                    env_seen_next = env_seen | env_done_in;
                    obs_seen_next = obs_seen | obs_done_in;
                    if ((env_seen | env_done_in) && (obs_seen | obs_done_in)) begin
                        step_cnt_next = '0;
                        state_next    = PHYS_START;
                    end
                end
            end
            PHYS_START: begin
                overrun_next = new_frame_in;
                wd_cnt_next  = '0;
                state_next   = PHYS_WAIT;
            end
            PHYS_WAIT: begin
                overrun_next = new_frame_in;
                if (wd_expired) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wd_cnt_next = wd_cnt + 1'b1;
                    if (phys_done_in) begin
                        step_cnt_next = step_cnt + 1'b1;
                        if ((step_cnt + 1'b1) == STEP_W'(NUM_PHYS_STEPS))
                            state_next = COMMIT;
                        else
                            state_next = PHYS_START;
                    end
                end
            end
            COMMIT: begin
                // A frame arriving exactly at commit is accepted, not an overrun.
                state_next = new_frame_in ? ENV_START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, internal counters and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state              <= IDLE;
            env_seen           <= 1'b0;
            obs_seen           <= 1'b0;
            step_cnt           <= '0;
            wd_cnt             <= '0;
            env_start_out      <= 1'b0;
            phys_start_out     <= 1'b0;
            commit_out         <= 1'b0;
            busy_out           <= 1'b0;
            overrun_out        <= 1'b0;
            timeout_out        <= 1'b0;
            error_out          <= 1'b0;
            skipped_frames_out <= 8'd0;
        end else begin
            state          <= state_next;
            env_seen       <= env_seen_next;
            obs_seen       <= obs_seen_next;
            step_cnt       <= step_cnt_next;
            wd_cnt         <= wd_cnt_next;
            env_start_out  <= (state_next == ENV_START);
            // The physics start pulse trails the PHYS_START cycle by one clock.
            phys_start_out <= (state == PHYS_START);
            commit_out     <= (state_next == COMMIT);
            busy_out       <= (state_next != IDLE);
            overrun_out    <= overrun_next;
            timeout_out    <= timeout_next;
            if (timeout_next) error_out <= 1'b1;
            if (overrun_next && (skipped_frames_out != 8'hFF))
                skipped_frames_out <= skipped_frames_out + 8'd1;
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    logic [20:0] frame_cnt;
    logic [20:0] frame_cnt_inc;
    logic [20:0] last_cycles;

    assign frame_cnt_inc = (frame_cnt == 21'h1FFFFF) ? frame_cnt : frame_cnt + 21'd1;

    // Frame length counter: the accepted new_frame cycle counts as cycle 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt   <= 21'd0;
            last_cycles <= 21'd0;
        end else begin
            if (state_next == ENV_START)
                frame_cnt <= 21'd1;
            else if (state != IDLE)
                frame_cnt <= frame_cnt_inc;
            if (state_next == COMMIT)
                last_cycles <= frame_cnt_inc;
        end
    end

    assign last_frame_cycles_out = last_cycles;
`else
    assign last_frame_cycles_out = 21'd0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed vector tables taken from the frame
// timeline, hand-written reset/saturation sequences, and a long randomized run
// whose expected outputs come from a frame-level timing model.
module tb_frame_sequencer;

    localparam int TO   = 100;
    localparam int NPS  = 2;
    localparam int MAXC = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        new_frame = 1'b0, env_done = 1'b0, obs_done = 1'b0, phys_done = 1'b0;
    logic        env_start, phys_start, commit, busy, overrun, timeout, error;
    logic [7:0]  skipped;
    logic [20:0] last_cycles;

    int checks = 0;
    int errors = 0;

    frame_sequencer #(.TIMEOUT_CYCLES(TO), .NUM_PHYS_STEPS(NPS)) dut (
        .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame),
        .env_start_out(env_start), .env_done_in(env_done), .obs_done_in(obs_done),
        .phys_start_out(phys_start), .phys_done_in(phys_done), .commit_out(commit),
        .busy_out(busy), .overrun_out(overrun), .timeout_out(timeout),
        .error_out(error), .skipped_frames_out(skipped),
        .last_frame_cycles_out(last_cycles)
    );

    always #5 clk = ~clk;

    // Timeline: stim = {new_frame, env_done, obs_done, phys_done}
    // exp_p = {env_start, phys_start, commit, overrun, timeout}, exp_b = {care, busy}
    logic [3:0]  stim     [MAXC];
    logic [4:0]  exp_p    [MAXC];
    logic [1:0]  exp_b    [MAXC];
    logic        exp_err  [MAXC];
    logic [7:0]  exp_skip [MAXC];
    logic [20:0] exp_last [MAXC];
    int          len_at   [MAXC];

    typedef struct {
        int         scen;
        int         cyc;
        logic [3:0] in;
        logic [4:0] pulses;
        logic [1:0] busy;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        {new_frame, env_done, obs_done, phys_done} = 4'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_timeline();
        for (int c = 0; c < MAXC; c++) begin
            stim[c] = '0; exp_p[c] = '0; exp_b[c] = '0;
            exp_err[c] = 1'b0; exp_skip[c] = '0; exp_last[c] = '0; len_at[c] = 0;
        end
    endtask

    // Drive one cycle of inputs and advance to just after the next edge.
    task automatic step(input logic [3:0] in);
        {new_frame, env_done, obs_done, phys_done} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int len, input bit full);
        for (int c = 0; c < len; c++) begin
            if (full) begin
                check($sformatf("outputs@%0d", c),
                      {env_start, phys_start, commit, overrun, timeout, busy, error, skipped, last_cycles},
                      {exp_p[c], exp_b[c][0], exp_err[c], exp_skip[c], exp_last[c]});
            end else begin
                check($sformatf("pulses@%0d", c),
                      {env_start, phys_start, commit, overrun, timeout}, exp_p[c]);
                if (exp_b[c][1]) check($sformatf("busy@%0d", c), busy, exp_b[c][0]);
            end
            step(stim[c]);
        end
        {new_frame, env_done, obs_done, phys_done} = 4'b0;
    endtask

    // Frame-level model: lays out random frames and derives each output event
    // time from the documented latencies.
    task automatic build_random(output int len);
        int t, t0, ws, ps, pw, e, de, dob, m, dp, kind, k, n, p, gap, sk, lastv;
        bit abort, err;
        for (int c = 0; c < MAXC; c++) exp_b[c] = 2'b10;
        t = 2;
        while (t < MAXC - 700) begin
            t0 = t;
            stim[t0][3] = 1'b1;
            exp_p[t0 + 1][4] = 1'b1;
            if ($urandom_range(0, 3) == 0) stim[t0 + 1][2:0] = 3'($urandom_range(1, 7));
            ws = t0 + 2;
            abort = 1'b0;
            e = 0;
            kind = int'($urandom_range(0, 9));
            de = int'($urandom_range(0, 12));
            dob = int'($urandom_range(0, 12));
            if (kind == 0) begin
                abort = 1'b1;
                e = ws + TO;
                stim[ws + de][2] = 1'b1;
                if ($urandom_range(0, 1) == 1) stim[ws + TO - 1][1] = 1'b1;
            end else begin
                if (kind == 1) de = TO - 2;
                stim[ws + de][2] = 1'b1;
                stim[ws + dob][1] = 1'b1;
                m = (de > dob) ? de : dob;
                ps = ws + m + 1;
                for (int s = 0; s < NPS; s++) begin
                    if (!abort) begin
                        exp_p[ps + 1][3] = 1'b1;
                        if ($urandom_range(0, 3) == 0) stim[ps][0] = 1'b1;
                        pw = ps + 1;
                        k = int'($urandom_range(0, 9));
                        if (k == 0) begin
                            abort = 1'b1;
                            e = pw + TO;
                            if ($urandom_range(0, 1) == 1) stim[pw + TO - 1][0] = 1'b1;
                        end else begin
                            dp = (k == 1) ? TO - 2 : int'($urandom_range(0, 10));
                            stim[pw + dp][0] = 1'b1;
                            ps = pw + dp + 1;
                        end
                    end
                end
                if (!abort) e = ps;
            end
            if (abort) exp_p[e][0] = 1'b1;
            else begin
                exp_p[e][2] = 1'b1;
                len_at[e] = e - t0;
            end
            for (int c = t0 + 1; c <= (abort ? e - 1 : e); c++) exp_b[c] = 2'b11;
            n = int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                p = int'($urandom_range(t0 + 1, e - 1));
                stim[p][3] = 1'b1;
                exp_p[p + 1][1] = 1'b1;
            end
            gap = int'($urandom_range(0, 3));
            for (int c = e; c < e + gap; c++) stim[c][2:0] = 3'($urandom_range(0, 7));
            t = e + gap;
        end
        len = t + 4;
        sk = 0;
        err = 1'b0;
        lastv = 0;
        for (int c = 0; c < len; c++) begin
            if (exp_p[c][1] && sk < 255) sk++;
            if (exp_p[c][0]) err = 1'b1;
`ifdef FRAME_SEQ_STATS_EN
            if (exp_p[c][2]) lastv = len_at[c];
`endif
            exp_skip[c] = 8'(sk);
            exp_err[c]  = err;
            exp_last[c] = 21'(lastv);
        end
    endtask

    initial begin
        int len;
        int exp_last0, exp_last1;

        // Nominal frame with one overrun in PHYS_WAIT.
        vecs[0]  = '{0, 0,  4'b1000, 5'b00000, 2'b10};
        vecs[1]  = '{0, 1,  4'b0000, 5'b10000, 2'b11};
        vecs[2]  = '{0, 10, 4'b0100, 5'b00000, 2'b00};
        vecs[3]  = '{0, 14, 4'b0010, 5'b00000, 2'b00};
        vecs[4]  = '{0, 16, 4'b0000, 5'b01000, 2'b00};
        vecs[5]  = '{0, 20, 4'b0001, 5'b00000, 2'b00};
        vecs[6]  = '{0, 22, 4'b0000, 5'b01000, 2'b00};
        vecs[7]  = '{0, 25, 4'b1000, 5'b00000, 2'b00};
        vecs[8]  = '{0, 26, 4'b0000, 5'b00010, 2'b00};
        vecs[9]  = '{0, 30, 4'b0001, 5'b00000, 2'b00};
        vecs[10] = '{0, 31, 4'b0000, 5'b00100, 2'b11};
        vecs[11] = '{0, 32, 4'b0000, 5'b00000, 2'b10};
        // Same-cycle dones, back-to-back frame at commit, env timeout, recovery.
        vecs[12] = '{1, 0,   4'b1000, 5'b00000, 2'b10};
        vecs[13] = '{1, 1,   4'b0000, 5'b10000, 2'b11};
        vecs[14] = '{1, 10,  4'b0110, 5'b00000, 2'b00};
        vecs[15] = '{1, 12,  4'b0000, 5'b01000, 2'b00};
        vecs[16] = '{1, 14,  4'b0001, 5'b00000, 2'b00};
        vecs[17] = '{1, 16,  4'b0000, 5'b01000, 2'b00};
        vecs[18] = '{1, 18,  4'b0001, 5'b00000, 2'b00};
        vecs[19] = '{1, 19,  4'b1000, 5'b00100, 2'b11};
        vecs[20] = '{1, 20,  4'b0000, 5'b10000, 2'b11};
        vecs[21] = '{1, 120, 4'b1000, 5'b00000, 2'b11};
        vecs[22] = '{1, 121, 4'b0000, 5'b00011, 2'b10};
        vecs[23] = '{1, 125, 4'b1000, 5'b00000, 2'b00};
        vecs[24] = '{1, 126, 4'b0000, 5'b10000, 2'b00};
        vecs[25] = '{1, 130, 4'b0110, 5'b00000, 2'b00};
        vecs[26] = '{1, 132, 4'b0000, 5'b01000, 2'b00};
        vecs[27] = '{1, 135, 4'b0001, 5'b00000, 2'b00};
        vecs[28] = '{1, 137, 4'b0000, 5'b01000, 2'b00};
        vecs[29] = '{1, 140, 4'b0001, 5'b00000, 2'b00};
        vecs[30] = '{1, 141, 4'b0000, 5'b00100, 2'b11};
        vecs[31] = '{1, 142, 4'b0000, 5'b00000, 2'b10};

`ifdef FRAME_SEQ_STATS_EN
        exp_last0 = 31;
        exp_last1 = 16;
`else
        exp_last0 = 0;
        exp_last1 = 0;
`endif

        do_reset();
        check("reset_state",
              {env_start, phys_start, commit, busy, overrun, timeout, error, skipped, last_cycles}, 64'd0);

        for (int s = 0; s < 2; s++) begin
            do_reset();
            clear_timeline();
            len = 0;
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].scen == s) begin
                    stim[vecs[i].cyc]  = stim[vecs[i].cyc] | vecs[i].in;
                    exp_p[vecs[i].cyc] = exp_p[vecs[i].cyc] | vecs[i].pulses;
                    if (vecs[i].busy[1]) exp_b[vecs[i].cyc] = vecs[i].busy;
                    if (vecs[i].cyc + 3 > len) len = vecs[i].cyc + 3;
                end
            end
            play(len, 1'b0);
            check($sformatf("scen%0d_skipped", s), skipped, 8'd1);
            check($sformatf("scen%0d_error", s), error, (s == 1) ? 1'b1 : 1'b0);
            check($sformatf("scen%0d_last", s), last_cycles, 21'((s == 0) ? exp_last0 : exp_last1));
        end

        // Async reset in PHYS_WAIT while error and skipped are nonzero.
        step(4'b1000);
        step(4'b0000);
        step(4'b0110);
        step(4'b0000);
        step(4'b0000);
        check("pre_reset_busy", {busy, error, skipped}, {1'b1, 1'b1, 8'd1});
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {env_start, phys_start, commit, busy, overrun, timeout, error, skipped, last_cycles}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b0001);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stale_done_quiet@%0d", c),
                  {env_start, phys_start, commit, busy, overrun, timeout, error, skipped}, 64'd0);
            step(4'b0000);
        end

        // new_frame held high: every busy-cycle pulse is an overrun; count saturates.
        do_reset();
        for (int c = 0; c <= 320; c++) begin
            if (c == 50) check("skipped_count_50", skipped, 8'd49);
            step(4'b1000);
        end
        step(4'b0000);
        check("skipped_saturated", skipped, 8'd255);
        check("error_after_timeouts", error, 1'b1);

        // Randomized frames against the timing model.
        do_reset();
        clear_timeline();
        build_random(len);
        play(len, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame scheduler for the game pipeline, in the clk_pixel domain.
- On each accepted new_frame it runs three steps in order: environment stream (manage_environment + get_obstacles_on_screen), then NUM_PHYS_STEPS physics substeps, then a single-cycle commit pulse.
- The commit pulse tells render-side double buffers (obstacle/car/camera snapshots) to swap.
- Guards against frame overrun and hung stages with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 1000000: max cycles spent in any wait state before abort.
- NUM_PHYS_STEPS, 1: physics substeps per frame (>=1).

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous active-high reset
- new_frame_in  input  1  one-cycle new-frame pulse from video_sig_gen
- env_start_out  output  1  one-cycle start pulse to manage_environment
- env_done_in  input  1  environment stream done pulse
- obs_done_in  input  1  obstacle collection done pulse
- phys_start_out  output  1  one-cycle start pulse per physics substep
- phys_done_in  input  1  physics substep done pulse
- commit_out  output  1  one-cycle buffer-swap pulse
- busy_out  output  1  high whenever state != IDLE
- overrun_out  output  1  one-cycle pulse: new_frame_in rejected
- timeout_out  output  1  one-cycle pulse: watchdog abort
- error_out  output  1  sticky, set by any timeout, cleared only by reset
- skipped_frames_out  output  8  saturating count of rejected frames
- last_frame_cycles_out  output  21  see Optional Feature

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_in, rst_in).
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered.
- States: IDLE, ENV_START, ENV_WAIT, PHYS_START, PHYS_WAIT, COMMIT.
- IDLE: new_frame_in -> ENV_START. env_start_out is high in the cycle after the pulse (latency 1).
- ENV_START (1 cycle): env_start_out=1, clear env/obs done latches, clear watchdog -> ENV_WAIT.
- ENV_WAIT: env_done_in and obs_done_in are latched independently and may arrive in any order or the same cycle. When both latches are set (a pulse arriving this cycle counts) -> PHYS_START; substep counter = 0.
- PHYS_START (1 cycle): phys_start_out=1, clear watchdog -> PHYS_WAIT. phys_done_in during PHYS_START is ignored.
- PHYS_WAIT: on phys_done_in, increment substep counter.
  - If count == NUM_PHYS_STEPS -> COMMIT.
  - Else -> PHYS_START.
- COMMIT (1 cycle): commit_out=1 -> IDLE. A new_frame_in during COMMIT is accepted and goes directly to ENV_START; it is not an overrun.
- Overrun:
  - new_frame_in in ENV_START, ENV_WAIT, PHYS_START or PHYS_WAIT -> overrun_out pulse next cycle; skipped_frames_out += 1, saturating at 255.
  - The current frame continues and no restart occurs.
- Watchdog: counts cycles in ENV_WAIT/PHYS_WAIT and resets on entry to either.
  - Reaching TIMEOUT_CYCLES -> timeout_out pulse, error_out=1, -> IDLE.
  - No commit is issued for the aborted frame.
  - A done pulse arriving in the same cycle as timeout loses: the timeout wins.
  - A new_frame_in in the abort cycle counts as overrun.
- Done pulses in IDLE, COMMIT or START states are ignored; they are not latched.
- Reset mid-operation: immediate return to IDLE. No pulse outputs are emitted on reset exit.

Optional Feature:
- Macro: FRAME_SEQ_STATS_EN.
- Defined: a 21-bit cycle counter starts at the accepted new_frame_in cycle. On COMMIT its value is loaded into last_frame_cycles_out, which holds until the next commit. Aborted frames do not update it. The counter saturates at 2^21-1.
- Undefined: last_frame_cycles_out is tied to 0 and no counter logic is generated.

Test Plan:
- Nominal (NUM_PHYS_STEPS=2, TIMEOUT_CYCLES=100), new_frame at cycle 0:
  - env_start_out at cycle 1.
  - env_done at 10, obs_done at 14 -> phys_start at 16.
  - phys_done at 20 -> second phys_start at 22.
  - phys_done at 30 -> commit_out at 31.
  - busy_out low at 32.
- Same-cycle dones: env_done and obs_done both at cycle 10 -> phys_start_out at cycle 12.
- Overrun: second new_frame while in PHYS_WAIT -> overrun_out 1 cycle, skipped_frames_out=1, single commit. Apply 300 overruns -> skipped_frames_out=255.
- Timeout: no env_done after start, TIMEOUT_CYCLES=100 -> timeout_out ~100 cycles into ENV_WAIT, error_out=1, no commit_out. The next new_frame runs normally and error_out stays 1.
- Back-to-back: new_frame during COMMIT cycle -> env_start_out next cycle, overrun_out stays 0.
- Async reset asserted mid-PHYS_WAIT -> all outputs 0 immediately. Stale phys_done after release -> no outputs. With FRAME_SEQ_STATS_EN, nominal case gives last_frame_cycles_out=31.
